// File: rtl/dcache_line_buffer.sv
// Refill line buffer for the non-blocking D-cache MSHR path: collects refill beats by
// (id, offset), tracks per-beat validity and serves 1-cycle-latency beat reads.
module dcache_line_buffer #(
    parameter int N_LINES = 4,
    parameter int BEATS   = 4,
    parameter int DATA_W  = 64,
    parameter int BYPASS  = 1,
    parameter int ID_W    = (N_LINES > 1) ? $clog2(N_LINES) : 1,
    parameter int OFF_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ID_W-1:0]     wr_id,
    input  logic [OFF_W-1:0]    wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_dup,
    input  logic                rd_valid,
    input  logic [ID_W-1:0]     rd_id,
    input  logic [OFF_W-1:0]    rd_offset,
    output logic                rd_resp_valid,
    output logic [DATA_W-1:0]   rd_resp_data,
    output logic                rd_resp_err,
    input  logic                free_valid,
    input  logic [ID_W-1:0]     free_id,
    output logic [N_LINES-1:0]  line_full
);

    logic [N_LINES-1:0][BEATS-1:0][DATA_W-1:0] data_q, data_d;
    logic [N_LINES-1:0][BEATS-1:0]             mask_q, mask_d;
    logic [N_LINES-1:0][BEATS-1:0]             wr_hit, rd_sel;
    logic [N_LINES-1:0]                        free_hit;
    logic [DATA_W-1:0]                         rd_beat_data;
    logic                                      wr_acc, rd_mask_hit, rd_bypass;
    logic                                      wr_dup_q, wr_dup_d;
    logic                                      resp_valid_q, resp_valid_d;
    logic                                      resp_err_q, resp_err_d;
    logic [DATA_W-1:0]                         resp_data_q, resp_data_d;

    // A free to the same entry back-pressures the write so the free always wins.
    assign wr_ready = !(free_valid && (free_id == wr_id));
    assign wr_acc   = wr_valid && wr_ready;

    // One-hot beat selects; out-of-range indices match no entry, dropping the write.
    always_comb begin
        for (int i = 0; i < N_LINES; i++) begin
            free_hit[i] = free_valid && (free_id == ID_W'(i));
            for (int b = 0; b < BEATS; b++) begin
                wr_hit[i][b] = wr_acc && (wr_id == ID_W'(i)) && (wr_offset == OFF_W'(b));
                rd_sel[i][b] = (rd_id == ID_W'(i)) && (rd_offset == OFF_W'(b));
            end
        end
    end

    // Next-state for beat data, validity mask and duplicate-write flag.
    always_comb begin
        wr_dup_d = 1'b0;
        for (int i = 0; i < N_LINES; i++) begin
            for (int b = 0; b < BEATS; b++) begin
                data_d[i][b] = wr_hit[i][b] ? wr_data : data_q[i][b];
                mask_d[i][b] = !free_hit[i] && (mask_q[i][b] || wr_hit[i][b]);
                wr_dup_d     = wr_dup_d || (wr_hit[i][b] && mask_q[i][b]);
            end
        end
    end

    // Read mux against pre-edge state, plus same-cycle write forwarding.
    always_comb begin
        rd_beat_data = {DATA_W{1'b0}};
        for (int i = 0; i < N_LINES; i++) begin
            for (int b = 0; b < BEATS; b++) begin
                rd_beat_data = rd_beat_data | (rd_sel[i][b] ? data_q[i][b] : {DATA_W{1'b0}});
            end
        end
        rd_mask_hit = |(rd_sel & mask_q);
        rd_bypass   = (BYPASS != 0) && (|(rd_sel & wr_hit));
    end

    // Response next-state; values hold while no read is issued.
    always_comb begin
        resp_valid_d = rd_valid;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        if (rd_valid) begin
            if (rd_bypass) begin
                resp_err_d  = 1'b0;
                resp_data_d = wr_data;
            end else if (rd_mask_hit) begin
                resp_err_d  = 1'b0;
                resp_data_d = rd_beat_data;
            end else begin
                resp_err_d  = 1'b1;
                resp_data_d = {DATA_W{1'b0}};
            end
        end else begin
            resp_err_d  = resp_err_q;
            resp_data_d = resp_data_q;
        end
    end

    // Line completion is decoded straight from the registered mask.
    always_comb begin
        for (int i = 0; i < N_LINES; i++) begin
            line_full[i] = &mask_q[i];
        end
    end

    // Control and response registers; reset drops any in-flight response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_q       <= {(N_LINES * BEATS){1'b0}};
            wr_dup_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= {DATA_W{1'b0}};
        end else begin
            mask_q       <= mask_d;
            wr_dup_q     <= wr_dup_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Beat storage is qualified by the mask, so it needs no reset.
    always_ff @(posedge clock) begin
        data_q <= data_d;
    end

    assign wr_dup        = wr_dup_q;
    assign rd_resp_valid = resp_valid_q;
    assign rd_resp_err   = resp_err_q;
    assign rd_resp_data  = resp_data_q;

endmodule

// File: tb/tb_dcache_line_buffer.sv
// Self-checking bench for dcache_line_buffer: directed vector table, corner-case
// sequences and randomized traffic against a beat-level reference model.
module tb_dcache_line_buffer;

    localparam int BYP = 1;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wr_valid, wr_ready, wr_dup;
    logic [1:0]  wr_id, wr_offset;
    logic [63:0] wr_data;
    logic        rd_valid, rd_resp_valid, rd_resp_err;
    logic [1:0]  rd_id, rd_offset;
    logic [63:0] rd_resp_data;
    logic        free_valid;
    logic [1:0]  free_id;
    logic [3:0]  line_full;

    int passed = 0;
    int total  = 0;

    // Reference model: per-beat valid flags and stored data, plus expected outputs.
    bit          m_valid [4][4];
    logic [63:0] m_data  [4][4];
    logic        exp_rv, exp_err, exp_dup;
    logic [63:0] exp_data;

    typedef struct {
        logic        wv;
        logic [1:0]  wid, woff;
        logic [63:0] wd;
        logic        rv;
        logic [1:0]  rid, roff;
        logic        e_rv, e_err;
        logic [63:0] e_data;
        logic [3:0]  e_full;
        logic        e_dup;
    } vec_t;

    vec_t tbl [12];

    dcache_line_buffer #(
        .N_LINES(4), .BEATS(4), .DATA_W(64), .BYPASS(BYP)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_id(wr_id),
        .wr_offset(wr_offset), .wr_data(wr_data), .wr_dup(wr_dup),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_offset(rd_offset),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .rd_resp_err(rd_resp_err),
        .free_valid(free_valid), .free_id(free_id), .line_full(line_full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    endtask

    function automatic logic [3:0] m_full();
        logic [3:0] f;
        for (int i = 0; i < 4; i++) begin
            f[i] = 1'b1;
            for (int b = 0; b < 4; b++) if (!m_valid[i][b]) f[i] = 1'b0;
        end
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++) m_valid[i][b] = 1'b0;
        exp_rv = 1'b0; exp_err = 1'b0; exp_dup = 1'b0; exp_data = 64'h0;
    endtask

    // One clock cycle: drive, predict from the model, then compare after the edge.
    task automatic step(input logic wv, input logic [1:0] wid, input logic [1:0] woff,
                        input logic [63:0] wd, input logic rv, input logic [1:0] rid,
                        input logic [1:0] roff, input logic fv, input logic [1:0] fid);
        logic acc, rdy;
        wr_valid = wv; wr_id = wid; wr_offset = woff; wr_data = wd;
        rd_valid = rv; rd_id = rid; rd_offset = roff;
        free_valid = fv; free_id = fid;
        #1;
        rdy = !(fv && (fid == wid));
        acc = wv && rdy;
        if (wv) chk("wr_ready", {63'h0, wr_ready}, {63'h0, rdy});
        exp_rv  = rv;
        exp_dup = acc && m_valid[wid][woff];
        if (rv) begin
            if (BYP != 0 && acc && wid == rid && woff == roff) begin
                exp_err = 1'b0; exp_data = wd;
            end else if (m_valid[rid][roff]) begin
                exp_err = 1'b0; exp_data = m_data[rid][roff];
            end else begin
                exp_err = 1'b1; exp_data = 64'h0;
            end
        end
        if (acc) begin
            m_data[wid][woff]  = wd;
            m_valid[wid][woff] = 1'b1;
        end
        if (fv) for (int b = 0; b < 4; b++) m_valid[fid][b] = 1'b0;
        @(posedge clock);
        #1;
        chk("resp_valid", {63'h0, rd_resp_valid}, {63'h0, exp_rv});
        chk("resp_err",   {63'h0, rd_resp_err},   {63'h0, exp_err});
        chk("resp_data",  rd_resp_data, exp_data);
        chk("wr_dup",     {63'h0, wr_dup},        {63'h0, exp_dup});
        chk("line_full",  {60'h0, line_full},     {60'h0, m_full()});
    endtask

    task automatic idle_step();
        step(1'b0, 2'd0, 2'd0, 64'h0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        wr_valid = 1'b0; rd_valid = 1'b0; free_valid = 1'b0;
        #1;
        chk("rst_resp_valid", {63'h0, rd_resp_valid}, 64'h0);
        chk("rst_resp_err",   {63'h0, rd_resp_err},   64'h0);
        chk("rst_resp_data",  rd_resp_data,           64'h0);
        chk("rst_wr_dup",     {63'h0, wr_dup},        64'h0);
        chk("rst_line_full",  {60'h0, line_full},     64'h0);
        model_reset();
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] held_d;
        logic        held_e;
        held_e = (BYP == 0);
        held_d = (BYP != 0) ? 64'h55 : 64'h0;
        tbl[0]  = '{1'b0, 2'd0, 2'd0, 64'h0,  1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 64'h0,  4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 2'd2, 2'd0, 64'hA0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 64'h0,  4'b0000, 1'b0};
        tbl[2]  = '{1'b1, 2'd2, 2'd1, 64'hA1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 64'h0,  4'b0000, 1'b0};
        tbl[3]  = '{1'b1, 2'd2, 2'd2, 64'hA2, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 64'h0,  4'b0000, 1'b0};
        tbl[4]  = '{1'b1, 2'd2, 2'd3, 64'hA3, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 64'h0,  4'b0100, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 2'd0, 64'h0,  1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 64'hA1, 4'b0100, 1'b0};
        tbl[6]  = '{1'b1, 2'd1, 2'd2, 64'h55, 1'b1, 2'd1, 2'd2, 1'b1, held_e, held_d, 4'b0100, 1'b0};
        tbl[7]  = '{1'b1, 2'd0, 2'd1, 64'h11, 1'b0, 2'd0, 2'd0, 1'b0, held_e, held_d, 4'b0100, 1'b0};
        tbl[8]  = '{1'b1, 2'd0, 2'd1, 64'h22, 1'b0, 2'd0, 2'd0, 1'b0, held_e, held_d, 4'b0100, 1'b1};
        tbl[9]  = '{1'b0, 2'd0, 2'd0, 64'h0,  1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 64'h22, 4'b0100, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 2'd0, 64'h0,  1'b1, 2'd1, 2'd2, 1'b1, 1'b0, 64'h55, 4'b0100, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 2'd0, 64'h0,  1'b1, 2'd3, 2'd0, 1'b1, 1'b1, 64'h0,  4'b0100, 1'b0};

        reset_n = 1'b0;
        wr_valid = 1'b0; wr_id = 2'd0; wr_offset = 2'd0; wr_data = 64'h0;
        rd_valid = 1'b0; rd_id = 2'd0; rd_offset = 2'd0;
        free_valid = 1'b0; free_id = 2'd0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("init_resp_valid", {63'h0, rd_resp_valid}, 64'h0);
        chk("init_line_full",  {60'h0, line_full},     64'h0);
        reset_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].wv, tbl[i].wid, tbl[i].woff, tbl[i].wd,
                 tbl[i].rv, tbl[i].rid, tbl[i].roff, 1'b0, 2'd0);
            chk($sformatf("vec%0d_rv", i),   {63'h0, rd_resp_valid}, {63'h0, tbl[i].e_rv});
            chk($sformatf("vec%0d_err", i),  {63'h0, rd_resp_err},   {63'h0, tbl[i].e_err});
            chk($sformatf("vec%0d_data", i), rd_resp_data,           tbl[i].e_data);
            chk($sformatf("vec%0d_full", i), {60'h0, line_full},     {60'h0, tbl[i].e_full});
            chk($sformatf("vec%0d_dup", i),  {63'h0, wr_dup},        {63'h0, tbl[i].e_dup});
        end

        // Fill id3, then free it while writing to it.
        for (int b = 0; b < 4; b++)
            step(1'b1, 2'd3, 2'(b), 64'h30 + 64'(b), 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
        chk("fill3_full", {60'h0, line_full}, {60'h0, 4'b1100});
        step(1'b1, 2'd3, 2'd0, 64'h99, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3);
        chk("free3_full", {63'h0, line_full[3]}, 64'h0);
        step(1'b0, 2'd0, 2'd0, 64'h0, 1'b1, 2'd3, 2'd0, 1'b0, 2'd0);
        chk("free3_read_err",  {63'h0, rd_resp_err}, 64'h1);
        chk("free3_read_data", rd_resp_data,         64'h0);

        // Write and free to different ids in the same cycle.
        step(1'b1, 2'd1, 2'd0, 64'h77, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2);
        chk("wf_full2", {63'h0, line_full[2]}, 64'h0);
        step(1'b0, 2'd0, 2'd0, 64'h0, 1'b1, 2'd1, 2'd0, 1'b0, 2'd0);
        chk("wf_read1", rd_resp_data, 64'h77);

        // Back-to-back reads across all ids with a mid-stream reset.
        for (int k = 0; k < 24; k++) begin
            step(1'b0, 2'd0, 2'd0, 64'h0, 1'b1, 2'(k % 4), 2'((k / 4) % 4), 1'b0, 2'd0);
            if (k == 10) pulse_reset();
        end
        idle_step();

        // Randomized traffic with biased read/write address collisions.
        for (int n = 0; n < 400; n++) begin
            logic        wv, rv, fv;
            logic [1:0]  wid, woff, rid, roff, fid;
            logic [63:0] wd;
            wv   = 1'($urandom_range(0, 1));
            wid  = 2'($urandom_range(0, 3));
            woff = 2'($urandom_range(0, 3));
            wd   = {$urandom, $urandom};
            rv   = 1'($urandom_range(0, 1));
            rid  = ($urandom_range(0, 2) == 0) ? wid  : 2'($urandom_range(0, 3));
            roff = ($urandom_range(0, 2) == 0) ? woff : 2'($urandom_range(0, 3));
            fv   = ($urandom_range(0, 7) == 0);
            fid  = ($urandom_range(0, 3) == 0) ? wid : 2'($urandom_range(0, 3));
            step(wv, wid, woff, wd, rv, rid, roff, fv, fid);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
